// File: rtl/hd44780_update_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// hd44780_update_arbiter_pkg
//   Shared definitions for the HD44780 display-update arbiter:
//   - FSM state encodings (2-bit) used by the arbiter top.
//   - Source-index constants shared with the rest of the HD44780 codebase.
//   - Helper that derives the source-index width from the source count.
// ----------------------------------------------------------------------------
package hd44780_update_arbiter_pkg;

  // Arbiter FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Well-known update sources of the HD44780 front end.
  localparam int SRC_CLOCK = 0;
  localparam int SRC_INPUT = 1;

  // Index width needed to name one of n sources (at least one bit).
  function automatic int src_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hd44780_update_arbiter_if.sv
// ----------------------------------------------------------------------------
// hd44780_update_arbiter_if
//   Request/acknowledge link between the update arbiter and the LCD writer.
//   Signals:
//     req  arbiter -> writer  update request, held until acknowledged
//     src  arbiter -> writer  index of the granted source, stable while req=1
//     ena  writer  -> arbiter acknowledge, consumes the current request
//   Modports: master (arbiter side), slave (writer side).
// ----------------------------------------------------------------------------
interface hd44780_update_arbiter_if #(
  parameter int SRC_W = 2
) ();
  logic             req;
  logic [SRC_W-1:0] src;
  logic             ena;

  modport master (output req, output src, input ena);
  modport slave  (input req, input src, output ena);
endinterface

// File: rtl/hd44780_rr_pick.sv
// ----------------------------------------------------------------------------
// hd44780_rr_pick
//   Combinational round-robin picker. Returns the first set bit of i_req
//   found when scanning cyclically upward starting just after i_last.
//   Ports:
//     i_req    in  N_SRC  request vector
//     i_last   in  SRC_W  index granted last time
//     o_idx    out SRC_W  chosen index (0 when nothing requested)
//     o_valid  out 1      at least one request present
// ----------------------------------------------------------------------------
module hd44780_rr_pick #(
  parameter int N_SRC = 4,
  parameter int SRC_W = 2
) (
  input  logic [N_SRC-1:0] i_req,
  input  logic [SRC_W-1:0] i_last,
  output logic [SRC_W-1:0] o_idx,
  output logic             o_valid
);

  // Cyclic scan; offsets are visited from farthest to nearest so the nearest
  // requesting source after the pointer is the last (winning) assignment.
  always_comb begin
    int w_k;
    w_k     = 0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N_SRC; i >= 1; i--) begin
      w_k = (int'(i_last) + i) % N_SRC;
      if (i_req[w_k]) begin
        o_idx   = SRC_W'(w_k);
        o_valid = 1'b1;
      end else begin
        o_valid = o_valid;
      end
    end
  end

endmodule

// File: rtl/hd44780_update_arbiter.sv
// ----------------------------------------------------------------------------
// hd44780_update_arbiter
//   Latches 1-cycle update events from N_SRC sources into sticky pending
//   flags and hands them, one at a time and round-robin, to the HD44780
//   writer over a req/ena handshake with a programmable hold-off between
//   refreshes. Events arriving for an already-pending source are counted in
//   a saturating merge counter.
//   Ports:
//     i_clk        in   1          clock, posedge
//     i_rst        in   1          synchronous reset, active-high
//     i_pulse      in   N_SRC      update event per source
//     i_mask       in   N_SRC      source enable; 0 drops and clears pending
//     i_holdoff    in   HOLDOFF_W  idle cycles forced after each acknowledge
//     i_merge_clr  in   1          clears o_merge_cnt
//     wr_if        master          req/src to writer, ena from writer
//     o_pending    out  N_SRC      registered pending flags
//     o_merge_cnt  out  MERGE_W    saturating merged-event count
// ----------------------------------------------------------------------------
module hd44780_update_arbiter
  import hd44780_update_arbiter_pkg::*;
#(
  parameter int N_SRC     = 4,
  parameter int HOLDOFF_W = 16,
  parameter int MERGE_W   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_SRC-1:0]     i_pulse,
  input  logic [N_SRC-1:0]     i_mask,
  input  logic [HOLDOFF_W-1:0] i_holdoff,
  input  logic                 i_merge_clr,
  hd44780_update_arbiter_if.master wr_if,
  output logic [N_SRC-1:0]     o_pending,
  output logic [MERGE_W-1:0]   o_merge_cnt
);

  localparam int SRC_W = src_width(N_SRC);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [N_SRC-1:0]     r_pending;
  logic [N_SRC-1:0]     w_pending_nxt;
  logic [SRC_W-1:0]     r_ptr;
  logic [SRC_W-1:0]     w_ptr_nxt;
  logic [HOLDOFF_W-1:0] r_cnt;
  logic [HOLDOFF_W-1:0] w_cnt_nxt;
  logic                 r_req;
  logic                 w_req_nxt;
  logic [SRC_W-1:0]     r_src;
  logic [SRC_W-1:0]     w_src_nxt;
  logic [MERGE_W-1:0]   r_merge;

  logic [SRC_W-1:0]     w_pick_idx;
  logic                 w_pick_valid;
  logic                 w_grant;
  logic [N_SRC-1:0]     w_grant_oh;
  logic                 w_merge_hit;

  hd44780_rr_pick #(
    .N_SRC (N_SRC),
    .SRC_W (SRC_W)
  ) u_pick (
    .i_req   (r_pending & i_mask),
    .i_last  (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // A grant is issued only from IDLE; its one-hot form clears the pending bit.
  assign w_grant    = (r_state == ST_IDLE) && w_pick_valid;
  assign w_grant_oh = w_grant ? ({{(N_SRC-1){1'b0}}, 1'b1} << w_pick_idx) : '0;

  // Mask clears, a new pulse sets (and beats a same-cycle grant), grant clears.
  assign w_pending_nxt = ((r_pending & ~w_grant_oh) | i_pulse) & i_mask;

  // Any enabled pulse landing on a flag that stays pending counts as one merge.
  assign w_merge_hit = |(i_pulse & i_mask & r_pending & ~w_grant_oh);

  // State, handshake outputs, pointer, hold-off counter and pending flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_req     <= 1'b0;
      r_src     <= '0;
      r_ptr     <= SRC_W'(N_SRC - 1);
      r_cnt     <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_req     <= w_req_nxt;
      r_src     <= w_src_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  // Saturating merge counter; clear has priority over increment.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_merge_clr) begin
      r_merge <= '0;
    end else if (w_merge_hit && (r_merge != {MERGE_W{1'b1}})) begin
      r_merge <= r_merge + MERGE_W'(1);
    end else begin
      r_merge <= r_merge;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) w_state_nxt = ST_REQ;
        else         w_state_nxt = ST_IDLE;
      end
      ST_REQ: begin
        if (wr_if.ena) w_state_nxt = (i_holdoff != '0) ? ST_HOLD : ST_IDLE;
        else           w_state_nxt = ST_REQ;
      end
      ST_HOLD: begin
        if (r_cnt == '0) w_state_nxt = ST_IDLE;
        else             w_state_nxt = ST_HOLD;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold-off counter.
  always_comb begin
    w_req_nxt = r_req;
    w_src_nxt = r_src;
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_req_nxt = 1'b1;
          w_src_nxt = w_pick_idx;
          w_ptr_nxt = w_pick_idx;
        end else begin
          w_req_nxt = 1'b0;
        end
      end
      ST_REQ: begin
        if (wr_if.ena) begin
          w_req_nxt = 1'b0;
          w_cnt_nxt = (i_holdoff != '0) ? (i_holdoff - HOLDOFF_W'(1)) : '0;
        end else begin
          w_req_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - HOLDOFF_W'(1);
        else             w_cnt_nxt = '0;
      end
      default: begin
        w_req_nxt = 1'b0;
        w_cnt_nxt = '0;
      end
    endcase
  end

  assign wr_if.req   = r_req;
  assign wr_if.src   = r_src;
  assign o_pending   = r_pending;
  assign o_merge_cnt = r_merge;

endmodule

// File: tb/tb_hd44780_update_arbiter.sv
// ----------------------------------------------------------------------------
// tb_hd44780_update_arbiter
//   Directed stimulus with hand-computed expectations. Each expected grant
//   (source index, and rise cycle where it is fixed) is queued when the
//   stimulus is issued; a negedge monitor pops and compares on every rising
//   edge of req. Flag and counter values are checked inline.
// ----------------------------------------------------------------------------
module tb_hd44780_update_arbiter;
  import hd44780_update_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int HW = 16;
  localparam int MW = 8;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  pulse;
  logic [N-1:0]  mask;
  logic [HW-1:0] holdoff;
  logic          merge_clr;
  logic [N-1:0]  pend;
  logic [MW-1:0] mcnt;

  hd44780_update_arbiter_if #(.SRC_W(SW)) bus ();

  hd44780_update_arbiter #(
    .N_SRC(N), .HOLDOFF_W(HW), .MERGE_W(MW)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_pulse     (pulse),
    .i_mask      (mask),
    .i_holdoff   (holdoff),
    .i_merge_clr (merge_clr),
    .wr_if       (bus),
    .o_pending   (pend),
    .o_merge_cnt (mcnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int src; int cyc; } exp_t;
  exp_t sb[$];

  int   checks   = 0;
  int   failures = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int s, input int c);
    exp_t e;
    e.src = s;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Grant monitor: on every rising req compare against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (bus.req === 1'b1 && req_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: got src %0d at cycle %0d expected none", bus.src, cyc);
      end else begin
        e = sb.pop_front();
        chk("grant_src", int'(bus.src), e.src);
        if (e.cyc >= 0) chk("grant_cycle", cyc, e.cyc);
      end
    end
    req_prev = bus.req;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    pulse     = '0;
    bus.ena   = 1'b0;
    merge_clr = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_req();
    int k;
    k = 0;
    while (bus.req !== 1'b1 && k < 50) begin
      step(1);
      k++;
    end
    chk("req_seen", int'(bus.req === 1'b1), 1);
  endtask

  task automatic ack(output int a);
    wait_req();
    bus.ena = 1'b1;
    a = cyc;
    step(1);
    bus.ena = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},  int'(bus.req), 0);
    chk({tag, "_src"},  int'(bus.src), 0);
    chk({tag, "_pend"}, int'(pend), 0);
    chk({tag, "_mcnt"}, int'(mcnt), 0);
  endtask

  initial begin
    int t;
    int a;
    int a2;
    mask    = 4'b1111;
    holdoff = 16'd0;
    do_reset();
    chk_reset_vals("rst");

    // 1: single pulse on source 2
    t = cyc;
    pulse = 4'b0100;
    push(2, t + 2);
    step(1);
    pulse = 4'b0000;
    chk("t1_pend_set", int'(pend), 4);
    ack(a);
    chk("t1_req_drop", int'(bus.req), 0);
    chk("t1_pend_clr", int'(pend), 0);

    // 2: round-robin 0,1,3 from reset pointer, then 0,1 from pointer 3
    do_reset();
    t = cyc;
    pulse = 4'b1011;
    push(0, t + 2); push(1, -1); push(3, -1);
    step(1);
    pulse = 4'b0000;
    chk("t2_pend", int'(pend), 11);
    ack(a); ack(a); ack(a);
    t = cyc;
    pulse = 4'b0011;
    push(0, t + 2); push(1, -1);
    step(1);
    pulse = 4'b0000;
    ack(a); ack(a);

    // 3: merging while a request is held, saturation, clear priority
    do_reset();
    t = cyc;
    pulse = 4'b0001;
    push(0, t + 2);
    step(1);
    pulse = 4'b0000;
    wait_req();
    pulse = 4'b0010;
    step(3);
    pulse = 4'b0000;
    chk("t3_merge2", int'(mcnt), 2);
    chk("t3_pend", int'(pend), 2);
    merge_clr = 1'b1;
    step(1);
    merge_clr = 1'b0;
    chk("t3_clr", int'(mcnt), 0);
    pulse = 4'b0010;
    step(301);
    chk("t3_sat", int'(mcnt), 255);
    merge_clr = 1'b1;
    step(1);
    merge_clr = 1'b0;
    pulse = 4'b0000;
    chk("t3_clr_prio", int'(mcnt), 0);
    push(1, -1);
    ack(a); ack(a);
    chk("t3_pend_end", int'(pend), 0);

    // 4: hold-off of 5 -> next request exactly 7 cycles after ena
    do_reset();
    holdoff = 16'd5;
    t = cyc;
    pulse = 4'b0011;
    push(0, t + 2);
    step(1);
    pulse = 4'b0000;
    ack(a);
    push(1, a + 7);
    ack(a2);
    holdoff = 16'd0;

    // 5: pulse coinciding with its own grant re-arms the flag; mask clears
    do_reset();
    t = cyc;
    pulse = 4'b0100;
    push(2, t + 2); push(2, -1);
    step(2);
    pulse = 4'b0000;
    chk("t5_rearm", int'(pend), 4);
    chk("t5_no_merge", int'(mcnt), 0);
    ack(a); ack(a);
    chk("t5_pend_end", int'(pend), 0);
    t = cyc;
    pulse = 4'b0001;
    push(0, t + 2);
    step(1);
    pulse = 4'b0000;
    wait_req();
    pulse = 4'b1000;
    step(1);
    pulse = 4'b0000;
    chk("t5_pend3", int'(pend), 8);
    mask = 4'b0111;
    step(1);
    chk("t5_mask_clr", int'(pend), 0);
    mask = 4'b1111;
    ack(a);
    step(5);
    chk("t5_no_grant", int'(bus.req), 0);

    // 6: reset during REQ and during HOLD, then pointer back at N_SRC-1
    do_reset();
    t = cyc;
    pulse = 4'b0110;
    push(1, t + 2);
    step(1);
    pulse = 4'b0000;
    wait_req();
    rst = 1'b1;
    step(1);
    chk_reset_vals("t6_req");
    rst = 1'b0;
    step(6);
    chk("t6_req_stale", int'(bus.req), 0);
    holdoff = 16'd5;
    t = cyc;
    pulse = 4'b0011;
    push(0, t + 2);
    step(1);
    pulse = 4'b0000;
    ack(a);
    chk("t6_hold_pend", int'(pend), 2);
    rst = 1'b1;
    step(1);
    chk_reset_vals("t6_hold");
    rst = 1'b0;
    holdoff = 16'd0;
    step(10);
    chk("t6_hold_stale", int'(bus.req), 0);
    t = cyc;
    pulse = 4'b1001;
    push(SRC_CLOCK, t + 2); push(3, -1);
    step(1);
    pulse = 4'b0000;
    ack(a); ack(a);

    step(3);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
